// File: rtl/sparcy_dcache_pkg.sv
// Shared widths and FSM state encoding for the direct-mapped write-through data cache.
package sparcy_dcache_pkg;
    localparam int LINE_ADDR_W    = 58;
    localparam int WORD_SEL_W     = 4;
    localparam int WORDS_PER_LINE = 16;
    localparam int DATA_W         = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_FILL   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } state_t;
endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: synchronous write, combinational read at a single set index.
module dcache_array
    import sparcy_dcache_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = LINE_ADDR_W - IDX_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IDX_W-1:0]      idx,
    input  logic [WORD_SEL_W-1:0] rd_word,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  wr_en,
    input  logic [WORD_SEL_W-1:0] wr_word,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  set_valid,
    input  logic                  clr_valid,
    input  logic [TAG_W-1:0]      wr_tag
);
    logic [DATA_W-1:0] data_mem [SETS][WORDS_PER_LINE];
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   valid_d;

    always_comb begin
        valid_d = valid_q;
        if (clr_valid) valid_d[idx] = 1'b0;
        if (set_valid) valid_d[idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) valid_q <= '0;
        else       valid_q <= valid_d;
    end

    // Data and tags need no reset: nothing reads them while the valid bit is clear.
    always_ff @(posedge clk) begin
        if (wr_en)     data_mem[idx][wr_word] <= wr_data;
        if (set_valid) tag_mem[idx]           <= wr_tag;
    end

    assign rd_valid = valid_q[idx];
    assign rd_tag   = tag_mem[idx];
    assign rd_data  = data_mem[idx][rd_word];
endmodule

// File: rtl/dcache_resp.sv
// Data-cache responder: request FSM, line-fill beat counter and registered outputs
// around a direct-mapped, write-through, no-write-allocate line store.
module dcache_resp
    import sparcy_dcache_pkg::*;
#(
    parameter int SETS = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_req,
    input  logic [LINE_ADDR_W-1:0] id_line_addr,
    input  logic [WORD_SEL_W-1:0]  id_word_select,
    input  logic [DATA_W-1:0]      id_data_to_cache,
    input  logic                   id_read_write_n,
    output logic                   ic_ack,
    output logic [DATA_W-1:0]      ic_data_from_cache,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [LINE_ADDR_W-1:0] mem_line_addr,
    output logic [WORD_SEL_W-1:0]  mem_word_select,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic                   mem_ack,
    input  logic                   mem_rvalid,
    input  logic [DATA_W-1:0]      mem_rdata
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = LINE_ADDR_W - IDX_W;

    state_t                 state_q, state_d;
    logic [LINE_ADDR_W-1:0] req_line_q, req_line_d;
    logic [WORD_SEL_W-1:0]  req_word_q, req_word_d;
    logic [DATA_W-1:0]      req_wdata_q, req_wdata_d;
    logic                   req_rd_q, req_rd_d;
    logic [WORD_SEL_W-1:0]  beat_q, beat_d;
    logic                   ic_ack_q, ic_ack_d;
    logic [DATA_W-1:0]      ic_data_q, ic_data_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [LINE_ADDR_W-1:0] mem_line_q, mem_line_d;
    logic [WORD_SEL_W-1:0]  mem_word_q, mem_word_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;

    logic                  arr_valid;
    logic [TAG_W-1:0]      arr_tag;
    logic [DATA_W-1:0]     arr_data;
    logic                  arr_we;
    logic [WORD_SEL_W-1:0] arr_wword;
    logic [DATA_W-1:0]     arr_wdata;
    logic                  arr_set_valid;
    logic                  arr_clr_valid;
    logic                  hit;

    dcache_array #(.SETS(SETS)) u_array (
        .clk       (clk),
        .reset     (reset),
        .idx       (req_line_q[IDX_W-1:0]),
        .rd_word   (req_word_q),
        .rd_valid  (arr_valid),
        .rd_tag    (arr_tag),
        .rd_data   (arr_data),
        .wr_en     (arr_we),
        .wr_word   (arr_wword),
        .wr_data   (arr_wdata),
        .set_valid (arr_set_valid),
        .clr_valid (arr_clr_valid),
        .wr_tag    (req_line_q[LINE_ADDR_W-1:IDX_W])
    );

    assign hit = arr_valid && (arr_tag == req_line_q[LINE_ADDR_W-1:IDX_W]);

    always_comb begin
        state_d       = state_q;
        req_line_d    = req_line_q;
        req_word_d    = req_word_q;
        req_wdata_d   = req_wdata_q;
        req_rd_d      = req_rd_q;
        beat_d        = beat_q;
        ic_ack_d      = 1'b0;
        ic_data_d     = ic_data_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_line_d    = mem_line_q;
        mem_word_d    = mem_word_q;
        mem_wdata_d   = mem_wdata_q;
        arr_we        = 1'b0;
        arr_wword     = req_word_q;
        arr_wdata     = req_wdata_q;
        arr_set_valid = 1'b0;
        arr_clr_valid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (id_req) begin
                    req_line_d  = id_line_addr;
                    req_word_d  = id_word_select;
                    req_wdata_d = id_data_to_cache;
                    req_rd_d    = id_read_write_n;
                    state_d     = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (req_rd_q && hit) begin
                    ic_ack_d  = 1'b1;
                    ic_data_d = arr_data;
                    state_d   = ST_RESP;
                end else if (req_rd_q) begin
                    // Invalidate up front so a partially refilled line never looks valid.
                    arr_clr_valid = 1'b1;
                    beat_d        = '0;
                    mem_req_d     = 1'b1;
                    mem_we_d      = 1'b0;
                    mem_line_d    = req_line_q;
                    mem_word_d    = '0;
                    state_d       = ST_FILL;
                end else begin
                    arr_we      = hit;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_line_d  = req_line_q;
                    mem_word_d  = req_word_q;
                    mem_wdata_d = req_wdata_q;
                    state_d     = ST_WRITE;
                end
            end
            ST_FILL: begin
                if (mem_rvalid) begin
                    arr_we    = 1'b1;
                    arr_wword = beat_q;
                    arr_wdata = mem_rdata;
                    beat_d    = beat_q + 4'd1;
                    if (beat_q == 4'hF) begin
                        arr_set_valid = 1'b1;
                        mem_req_d     = 1'b0;
                        ic_ack_d      = 1'b1;
                        ic_data_d     = (req_word_q == 4'hF) ? mem_rdata : arr_data;
                        state_d       = ST_RESP;
                    end
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    ic_ack_d  = 1'b1;
                    ic_data_d = '0;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_line_q  <= '0;
            req_word_q  <= '0;
            req_wdata_q <= '0;
            req_rd_q    <= 1'b0;
            beat_q      <= '0;
            ic_ack_q    <= 1'b0;
            ic_data_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_line_q  <= '0;
            mem_word_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_line_q  <= req_line_d;
            req_word_q  <= req_word_d;
            req_wdata_q <= req_wdata_d;
            req_rd_q    <= req_rd_d;
            beat_q      <= beat_d;
            ic_ack_q    <= ic_ack_d;
            ic_data_q   <= ic_data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_line_q  <= mem_line_d;
            mem_word_q  <= mem_word_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign ic_ack             = ic_ack_q;
    assign ic_data_from_cache = ic_data_q;
    assign mem_req            = mem_req_q;
    assign mem_we             = mem_we_q;
    assign mem_line_addr      = mem_line_q;
    assign mem_word_select    = mem_word_q;
    assign mem_wdata          = mem_wdata_q;
endmodule

// File: tb/tb_dcache_resp.sv
// Directed bench for dcache_resp: a behavioural memory with configurable beat gaps
// plus one task per scenario, each comparing against hand-derived values.
module tb_dcache_resp;
    logic        clk;
    logic        reset;
    logic        id_req;
    logic [57:0] id_line_addr;
    logic [3:0]  id_word_select;
    logic [31:0] id_data_to_cache;
    logic        id_read_write_n;
    logic        ic_ack;
    logic [31:0] ic_data_from_cache;
    logic        mem_req;
    logic        mem_we;
    logic [57:0] mem_line_addr;
    logic [3:0]  mem_word_select;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    dcache_resp dut (
        .clk                (clk),
        .reset              (reset),
        .id_req             (id_req),
        .id_line_addr       (id_line_addr),
        .id_word_select     (id_word_select),
        .id_data_to_cache   (id_data_to_cache),
        .id_read_write_n    (id_read_write_n),
        .ic_ack             (ic_ack),
        .ic_data_from_cache (ic_data_from_cache),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_line_addr      (mem_line_addr),
        .mem_word_select    (mem_word_select),
        .mem_wdata          (mem_wdata),
        .mem_ack            (mem_ack),
        .mem_rvalid         (mem_rvalid),
        .mem_rdata          (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Memory model: unwritten words read back as (line<<8)+word; writes are remembered.
    logic [31:0] mem_store [logic [61:0]];
    int          gap = 0;
    int          gap_left = 0;
    int          beat_k = 0;
    int          fill_cnt = 0;
    int          wr_cnt = 0;
    int          rd_ws_err = 0;
    logic [57:0] fill_line = '0;
    logic [57:0] last_w_line = '0;
    logic [3:0]  last_w_word = '0;
    logic [31:0] last_w_data = '0;

    function automatic logic [31:0] mem_word(input logic [57:0] line, input int k);
        logic [61:0] key;
        key = {line, 4'(k)};
        if (mem_store.exists(key)) return mem_store[key];
        return (32'(line[23:0]) << 8) + 32'(k);
    endfunction

    always @(negedge clk) begin
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        if (reset) begin
            beat_k   = 0;
            gap_left = 0;
        end else if (mem_req && mem_we) begin
            mem_ack     = 1'b1;
            wr_cnt++;
            last_w_line = mem_line_addr;
            last_w_word = mem_word_select;
            last_w_data = mem_wdata;
            mem_store[{mem_line_addr, mem_word_select}] = mem_wdata;
        end else if (mem_req) begin
            if (gap_left > 0) begin
                gap_left--;
            end else begin
                if (beat_k == 0) begin
                    fill_cnt++;
                    fill_line = mem_line_addr;
                    if (mem_word_select !== 4'd0) rd_ws_err++;
                end
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(mem_line_addr, beat_k);
                beat_k     = (beat_k + 1) % 16;
                gap_left   = (beat_k == 0) ? 0 : gap;
            end
        end
    end

    int last_ack_cyc = 0;

    task automatic do_req(input logic [57:0] line, input logic [3:0] ws, input logic [31:0] wd,
                          input logic rd, output logic [31:0] data, output int lat);
        lat = 0;
        @(negedge clk);
        id_req           = 1'b1;
        id_line_addr     = line;
        id_word_select   = ws;
        id_data_to_cache = wd;
        id_read_write_n  = rd;
        do begin
            @(negedge clk);
            lat++;
        end while (!ic_ack && lat < 400);
        data         = ic_data_from_cache;
        last_ack_cyc = cyc;
        // Requester keeps id_req high through the ack cycle.
        @(posedge clk);
        #1 id_req = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({ic_ack, mem_req, mem_we} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got ack/req/we=%b expected 000", {ic_ack, mem_req, mem_we});
        end
        checks++;
        if ({ic_data_from_cache, mem_wdata} !== 64'd0 || mem_line_addr !== 58'd0 || mem_word_select !== 4'd0) begin
            errors++;
            $display("FAIL reset_data: got data=%h wdata=%h line=%h ws=%h expected all zero",
                     ic_data_from_cache, mem_wdata, mem_line_addr, mem_word_select);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({ic_ack, mem_req} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset: got ack/req=%b expected 00", {ic_ack, mem_req});
        end
    endtask

    task automatic test_cold_load();
        logic [31:0] d;
        int lat;
        int f0;
        f0 = fill_cnt;
        do_req(58'h10, 4'd3, 32'h0, 1'b1, d, lat);
        checks++;
        if (d !== 32'h0000_1003) begin
            errors++;
            $display("FAIL cold_load_data: got %h expected 00001003", d);
        end
        checks++;
        if (lat != 18) begin
            errors++;
            $display("FAIL cold_load_latency: got %0d expected 18", lat);
        end
        checks++;
        if (fill_cnt != f0 + 1 || fill_line !== 58'h10 || rd_ws_err != 0) begin
            errors++;
            $display("FAIL cold_load_fill: got fills=%0d line=%h wserr=%0d expected fills=%0d line=10 wserr=0",
                     fill_cnt - f0, fill_line, rd_ws_err, 1);
        end
    endtask

    task automatic test_hit();
        logic [31:0] d;
        int lat;
        int f0;
        f0 = fill_cnt;
        do_req(58'h10, 4'd7, 32'h0, 1'b1, d, lat);
        checks++;
        if (d !== 32'h0000_1007 || lat != 2) begin
            errors++;
            $display("FAIL load_hit: got data=%h lat=%0d expected data=00001007 lat=2", d, lat);
        end
        checks++;
        if (fill_cnt != f0) begin
            errors++;
            $display("FAIL load_hit_no_mem: got %0d new fills expected 0", fill_cnt - f0);
        end
    endtask

    task automatic test_store_hit();
        logic [31:0] d;
        int lat;
        int w0;
        w0 = wr_cnt;
        do_req(58'h10, 4'd7, 32'hDEAD_BEEF, 1'b0, d, lat);
        checks++;
        if (d !== 32'h0 || lat != 3) begin
            errors++;
            $display("FAIL store_hit_ack: got data=%h lat=%0d expected data=00000000 lat=3", d, lat);
        end
        checks++;
        if (wr_cnt != w0 + 1 || last_w_line !== 58'h10 || last_w_word !== 4'd7 || last_w_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL store_hit_write: got n=%0d line=%h word=%0d data=%h expected n=1 line=10 word=7 data=deadbeef",
                     wr_cnt - w0, last_w_line, last_w_word, last_w_data);
        end
        do_req(58'h10, 4'd7, 32'h0, 1'b1, d, lat);
        checks++;
        if (d !== 32'hDEAD_BEEF || lat != 2) begin
            errors++;
            $display("FAIL store_hit_readback: got data=%h lat=%0d expected data=deadbeef lat=2", d, lat);
        end
    endtask

    task automatic test_store_miss();
        logic [31:0] d;
        int lat;
        int f0;
        f0 = fill_cnt;
        do_req(58'h21, 4'd5, 32'hCAFE_0001, 1'b0, d, lat);
        checks++;
        if (d !== 32'h0 || lat != 3 || last_w_line !== 58'h21 || last_w_data !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL store_miss: got data=%h lat=%0d wline=%h wdata=%h expected 0 3 21 cafe0001",
                     d, lat, last_w_line, last_w_data);
        end
        do_req(58'h21, 4'd5, 32'h0, 1'b1, d, lat);
        checks++;
        if (d !== 32'hCAFE_0001 || lat != 18 || fill_cnt != f0 + 1) begin
            errors++;
            $display("FAIL store_miss_no_alloc: got data=%h lat=%0d fills=%0d expected cafe0001 18 1",
                     d, lat, fill_cnt - f0);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] d;
        int lat;
        int f0;
        f0 = fill_cnt;
        do_req(58'h20, 4'd2, 32'h0, 1'b1, d, lat);
        checks++;
        if (d !== 32'h0000_2002 || lat != 18) begin
            errors++;
            $display("FAIL conflict_evict: got data=%h lat=%0d expected 00002002 18", d, lat);
        end
        do_req(58'h10, 4'd7, 32'h0, 1'b1, d, lat);
        checks++;
        if (d !== 32'hDEAD_BEEF || lat != 18 || fill_cnt != f0 + 2) begin
            errors++;
            $display("FAIL conflict_reload: got data=%h lat=%0d fills=%0d expected deadbeef 18 2",
                     d, lat, fill_cnt - f0);
        end
    endtask

    task automatic test_gap_fill();
        logic [31:0] d;
        int lat;
        int f0;
        int w0;
        int acks;
        gap = 2;
        do_req(58'h35, 4'd15, 32'h0, 1'b1, d, lat);
        gap = 0;
        f0 = fill_cnt;
        w0 = wr_cnt;
        checks++;
        if (d !== 32'h0000_350F || lat != 48) begin
            errors++;
            $display("FAIL gap_fill_word15: got data=%h lat=%0d expected 0000350f 48", d, lat);
        end
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ic_ack || mem_req) acks++;
        end
        checks++;
        if (acks != 0 || fill_cnt != f0 || wr_cnt != w0) begin
            errors++;
            $display("FAIL no_duplicate: got busy=%0d fills=%0d writes=%0d expected 0 0 0",
                     acks, fill_cnt - f0, wr_cnt - w0);
        end
        do_req(58'h35, 4'd15, 32'h0, 1'b1, d, lat);
        checks++;
        if (d !== 32'h0000_350F || lat != 2) begin
            errors++;
            $display("FAIL gap_fill_hit: got data=%h lat=%0d expected 0000350f 2", d, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1;
        logic [31:0] d2;
        int lat;
        int a1;
        do_req(58'h10, 4'd3, 32'h0, 1'b1, d1, lat);
        a1 = last_ack_cyc;
        do_req(58'h10, 4'd7, 32'h0, 1'b1, d2, lat);
        checks++;
        if (d1 !== 32'h0000_1003 || d2 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL back_to_back_data: got %h %h expected 00001003 deadbeef", d1, d2);
        end
        checks++;
        if (last_ack_cyc - a1 != 3) begin
            errors++;
            $display("FAIL back_to_back_spacing: got %0d cycles expected 3", last_ack_cyc - a1);
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] d;
        int lat;
        int f0;
        int n;
        int acks;
        f0 = fill_cnt;
        @(negedge clk);
        id_req          = 1'b1;
        id_line_addr    = 58'h44;
        id_word_select  = 4'd1;
        id_read_write_n = 1'b1;
        n = 0;
        while (beat_k != 8 && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || ic_ack !== 1'b0 || n >= 100) begin
            errors++;
            $display("FAIL reset_mid_fill_abort: got mem_req=%b ack=%b waited=%0d expected 0 0 <100",
                     mem_req, ic_ack, n);
        end
        id_req = 1'b0;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (ic_ack) acks++;
        end
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ic_ack || mem_req) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL reset_mid_fill_quiet: got %0d busy cycles expected 0", acks);
        end
        do_req(58'h44, 4'd1, 32'h0, 1'b1, d, lat);
        checks++;
        if (d !== 32'h0000_4401 || lat != 18 || fill_cnt != f0 + 2) begin
            errors++;
            $display("FAIL reset_mid_fill_refetch: got data=%h lat=%0d fills=%0d expected 00004401 18 2",
                     d, lat, fill_cnt - f0);
        end
    endtask

    initial begin
        reset            = 1'b1;
        id_req           = 1'b0;
        id_line_addr     = '0;
        id_word_select   = '0;
        id_data_to_cache = '0;
        id_read_write_n  = 1'b1;
        mem_ack          = 1'b0;
        mem_rvalid       = 1'b0;
        mem_rdata        = '0;
        test_reset();
        test_cold_load();
        test_hit();
        test_store_hit();
        test_store_miss();
        test_conflict();
        test_gap_fill();
        test_back_to_back();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
